// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory boot loader.
package imem_loader_pkg;

    localparam int IMEM_DEPTH = 1024;

    typedef enum logic [2:0] {
        S_COUNT = 3'd0,
        S_DATA  = 3'd1,
        S_CHECK = 3'd2,
        S_DONE  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Packs accepted stream bytes MSB-first into 32-bit words.
module byte_assembler (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_fire,
    input  logic [7:0]  in_data,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] shift_q, shift_d;

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (in_fire) begin
            cnt_d   = cnt_q + 2'd1;
            shift_d = {shift_q[23:0], in_data};
        end
    end

    // The completed word is presented in the same cycle as its 4th byte so the
    // loader can register its outputs on that very edge.
    assign word       = shift_d;
    assign word_valid = in_fire && (cnt_q == 2'd3);

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses COUNT / DATA / CHECK words, writes instruction memory
// and releases the CPU from reset once the XOR checksum matches.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);

    state_t      state_q, state_d;
    logic [31:0] n_q, n_d;
    logic [9:0]  k_q, k_d;
    logic [31:0] xor_q, xor_d;
    logic        wr_en_q, wr_en_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        cpu_reset_q, cpu_reset_d;

    logic [31:0] word;
    logic        word_valid;
    logic        in_fire;
    logic        last_data;

    assign in_ready = reset && (state_q == S_COUNT || state_q == S_DATA || state_q == S_CHECK);
    assign in_fire  = in_valid && in_ready;

    byte_assembler u_asm (
        .clock      (clock),
        .reset      (reset),
        .in_fire    (in_fire),
        .in_data    (in_data),
        .word       (word),
        .word_valid (word_valid)
    );

    assign last_data = ({22'd0, k_q} == n_q - 32'd1);

    always_ff @(posedge clock) begin
        if (!reset) state_q <= S_COUNT;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (word_valid) begin
            case (state_q)
                S_COUNT: begin
                    if (word > 32'(DEPTH)) state_d = S_ERROR;
                    else if (word == '0)   state_d = S_CHECK;
                    else                   state_d = S_DATA;
                end
                S_DATA:  if (last_data) state_d = S_CHECK;
                S_CHECK: state_d = (word == xor_q) ? S_DONE : S_ERROR;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        n_d         = n_q;
        k_d         = k_q;
        xor_d       = xor_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        if (word_valid) begin
            case (state_q)
                S_COUNT: n_d = word;
                S_DATA: begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = {20'd0, k_q, 2'b00};
                    wr_data_d = word;
                    xor_d     = xor_q ^ word;
                    k_d       = k_q + 10'd1;
                end
                default: ;
            endcase
        end
        // Flags follow the terminal state so they rise on the deciding edge.
        done_d      = (state_d == S_DONE);
        error_d     = (state_d == S_ERROR);
        cpu_reset_d = done_d;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            n_q         <= '0;
            k_q         <= '0;
            xor_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cpu_reset_q <= 1'b0;
        end else begin
            n_q         <= n_d;
            k_q         <= k_d;
            xor_q       <= xor_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            done_q      <= done_d;
            error_q     <= error_d;
            cpu_reset_q <= cpu_reset_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign done      = done_q;
    assign error     = error_q;
    assign cpu_reset = cpu_reset_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader against a stream-level model.
module tb_imem_loader;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_reset;
    logic        done;
    logic        error;

    int errors = 0;
    int checks = 0;

    logic [31:0] stim[$];
    wr_t         exp_q[$];
    bit          exp_done, exp_err;
    int          term_word;
    bit          chk_spacing;
    int          cyc = 0;
    int          last_wr_cyc = -1;

    imem_loader #(.DEPTH(1024)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the next expected write, in order.
    always @(negedge clock) begin
        cyc <= cyc + 1;
        if (wr_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", wr_addr, wr_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (wr_addr !== e.addr || wr_data !== e.data) begin
                    errors++;
                    $display("FAIL write: got %h/%h expected %h/%h", wr_addr, wr_data, e.addr, e.data);
                end
                if (chk_spacing && last_wr_cyc >= 0 && (cyc - last_wr_cyc) != 4) begin
                    errors++;
                    $display("FAIL write_spacing: got %0d cycles expected 4", cyc - last_wr_cyc);
                end
            end
            last_wr_cyc = cyc;
        end
    end

    // Reference: expected writes and final flags from the stream rules.
    task automatic model();
        logic [31:0] n, x;
        exp_q.delete();
        n = stim[0];
        exp_done = 0;
        exp_err  = 0;
        if (n > 32'd1024) begin
            exp_err   = 1;
            term_word = 0;
        end else begin
            x = 0;
            for (int i = 0; i < int'(n); i++) begin
                wr_t w;
                w.addr = 32'(i) * 4;
                w.data = stim[1 + i];
                exp_q.push_back(w);
                x ^= stim[1 + i];
            end
            term_word = int'(n) + 1;
            if (stim[term_word] == x) exp_done = 1;
            else                      exp_err  = 1;
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        reset    = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
    endtask

    task automatic run_stream(input int max_gap);
        int gap;
        model();
        chk_spacing = (max_gap == 0);
        last_wr_cyc = -1;
        for (int w = 0; w < stim.size(); w++) begin
            for (int b = 0; b < 4; b++) begin
                gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
                for (int g = 0; g < gap; g++) begin
                    in_valid = 1'b0;
                    @(posedge clock); #1;
                end
                in_valid = 1'b1;
                in_data  = stim[w][31 - 8*b -: 8];
                if (w > term_word) chk("ready_after_term", 32'(in_ready), 32'd0);
                if (w == term_word && b == 3) begin
                    chk("done_before_last", 32'(done), 32'd0);
                    chk("error_before_last", 32'(error), 32'd0);
                end
                @(posedge clock); #1;
                if (w == term_word && b == 3) begin
                    chk("done", 32'(done), 32'(exp_done));
                    chk("error", 32'(error), 32'(exp_err));
                    chk("cpu_reset", 32'(cpu_reset), 32'(exp_done));
                    chk("in_ready_term", 32'(in_ready), 32'd0);
                end
            end
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("writes_outstanding", 32'(exp_q.size()), 32'd0);
        chk("done_sticky", 32'(done), 32'(exp_done));
        chk("error_sticky", 32'(error), 32'(exp_err));
    endtask

    task automatic load_t1(input logic [31:0] chkw);
        stim.delete();
        stim.push_back(32'h0000_0002);
        stim.push_back(32'h8C08_0000);
        stim.push_back(32'h0109_5020);
        stim.push_back(chkw);
    endtask

    initial begin
        int n;
        logic [31:0] x, d;

        // Reset state
        in_valid = 1'b1;
        in_data  = 8'hAA;
        @(posedge clock); #1;
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", wr_addr, 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);

        // Test 1: good image, continuous
        load_t1(32'h8D01_5020);
        run_stream(0);

        // Test 2: bad checksum, trailing bytes must not be consumed
        do_reset();
        load_t1(32'h8D01_5021);
        stim.push_back(32'h1234_5678);
        run_stream(0);

        // Test 3: empty image
        do_reset();
        stim.delete();
        stim.push_back(32'h0);
        stim.push_back(32'h0);
        run_stream(0);

        // Test 4: oversize count
        do_reset();
        stim.delete();
        stim.push_back(32'h0000_0401);
        stim.push_back(32'hDEAD_BEEF);
        run_stream(0);

        // Test 5: test-1 stream with random gaps
        do_reset();
        load_t1(32'h8D01_5020);
        run_stream(3);

        // Test 6: reset after 6 bytes (byte during reset is dropped), then restart
        do_reset();
        exp_q.delete();
        load_t1(32'h8D01_5020);
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = stim[i / 4][31 - 8*(i % 4) -: 8];
            @(posedge clock); #1;
        end
        in_data = 8'h00;
        reset   = 1'b0;
        #1;
        chk("in_ready_in_rst", 32'(in_ready), 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        run_stream(0);

        // Full-capacity image: exercises the top address and k wrap
        do_reset();
        stim.delete();
        stim.push_back(32'd1024);
        x = 0;
        for (int i = 0; i < 1024; i++) begin
            d = $urandom;
            stim.push_back(d);
            x ^= d;
        end
        stim.push_back(x);
        run_stream(0);

        // Random images, some with corrupted checksum
        for (int r = 0; r < 6; r++) begin
            do_reset();
            stim.delete();
            n = int'($urandom_range(1, 8));
            stim.push_back(32'(n));
            x = 0;
            for (int i = 0; i < n; i++) begin
                d = $urandom;
                stim.push_back(d);
                x ^= d;
            end
            if ($urandom_range(0, 1) == 1) x ^= (32'd1 << $urandom_range(0, 31));
            stim.push_back(x);
            stim.push_back($urandom);
            run_stream(int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
